// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e   : controller states (IDLE -> CALC -> DONE -> IDLE)
//   DEFAULT_WIDTH : default operand/result width
//   cnt_width()   : bit counter width for a given operand width
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // The counter runs WIDTH-1 down to 0, which always fits in $clog2(WIDTH) bits.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division step (combinational).
//   rem_in  [WIDTH:0]   partial remainder before the step
//   quo_msb             dividend bit shifted into the remainder
//   y       [WIDTH-1:0] divisor
//   rem_out [WIDTH:0]   partial remainder after trial subtract / restore
//   q_bit               resolved quotient bit
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_in, quo_msb};
    // Extra MSB of trial acts as the borrow/sign bit of the subtraction.
    trial   = shifted - {2'b00, y};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned multi-cycle restoring divider: x = q*y + r, r < y.
// One quotient bit is resolved per clock; start/done handshake.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted only while busy==0
//   x, y   dividend/divisor, sampled on the accepting edge
//   busy   high whenever the controller is not idle
//   done   one-cycle pulse, q/r/dbz valid
//   q, r   registered quotient / remainder, held until the next result
//   dbz    divide-by-zero flag (q=all-ones, r=x), qualified by done
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  div_state_e       state, state_next;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] y_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quo_shifted;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_msb (quo[WIDTH-1]),
    .y       (y_reg),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  assign quo_shifted = {quo[WIDTH-2:0], step_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (y != '0) ? ST_CALC : ST_DONE;
      ST_CALC: if (cnt == '0) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      y_reg <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            y_reg <= y;
            if (y != '0) begin
              rem <= '0;
              quo <= x;
              cnt <= CNT_W'(WIDTH - 1);
            end else begin
              q   <= '1;
              r   <= x;
              dbz <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          rem <= step_rem;
          quo <= quo_shifted;
          if (cnt == '0) begin
            // Final step: publish the freshly resolved bit directly.
            q   <= quo_shifted;
            r   <= step_rem[WIDTH-1:0];
            dbz <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0;
  logic       busy4, done4, dbz4;
  logic [3:0] q4, r4;

  logic       start2 = 1'b0;
  logic [1:0] x2 = '0, y2 = '0;
  logic       busy2, done2, dbz2;
  logic [1:0] q2, r2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  seq_restoring_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .q(q4), .r(r4), .dbz(dbz4)
  );

  seq_restoring_divider #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .q(q2), .r(r2), .dbz(dbz2)
  );

  // Issue one request on the 4-bit DUT; lat = edges after the accepting edge
  // until done is seen (20 means it never came). Returns in IDLE.
  task automatic run4(input logic [3:0] xv, input logic [3:0] yv,
                      output logic [3:0] qo, output logic [3:0] ro,
                      output logic dbzo, output int lat);
    @(negedge clk); x4 = xv; y4 = yv; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    qo = q4; ro = r4; dbzo = dbz4;
    if (done4 === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run2(input logic [1:0] xv, input logic [1:0] yv,
                      output logic [1:0] qo, output logic [1:0] ro,
                      output logic dbzo, output int lat);
    @(negedge clk); x2 = xv; y2 = yv; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    qo = q2; ro = r2; dbzo = dbz2;
    if (done2 === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done4 got=%b exp=0", done4); end
    total++; if (q4 !== 4'd0 || r4 !== 4'd0) begin bad++; $display("FAIL reset_qr4 got=%0d/%0d exp=0/0", q4, r4); end
    total++; if (dbz4 !== 1'b0) begin bad++; $display("FAIL reset_dbz4 got=%b exp=0", dbz4); end
    total++; if (busy2 !== 1'b0 || done2 !== 1'b0 || q2 !== 2'd0 || r2 !== 2'd0 || dbz2 !== 1'b0) begin
      bad++; $display("FAIL reset_dut2 got busy=%b done=%b q=%0d r=%0d dbz=%b exp=all 0", busy2, done2, q2, r2, dbz2);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [3:0] qv, rv; logic dv; int lat;
    run4(4'd13, 4'd3, qv, rv, dv, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    total++; if (qv !== 4'd4) begin bad++; $display("FAIL basic_q got=%0d exp=4", qv); end
    total++; if (rv !== 4'd1) begin bad++; $display("FAIL basic_r got=%0d exp=1", rv); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", dv); end
    total++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      bad++; $display("FAIL basic_done_pulse got done=%b busy=%b exp=0/0", done4, busy4);
    end
  endtask

  task automatic test_div_by_zero;
    logic [3:0] qv, rv; logic dv; int lat;
    run4(4'd7, 4'd0, qv, rv, dv, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL dbz_latency got=%0d exp=0", lat); end
    total++; if (qv !== 4'd15) begin bad++; $display("FAIL dbz_q got=%0d exp=15", qv); end
    total++; if (rv !== 4'd7) begin bad++; $display("FAIL dbz_r got=%0d exp=7", rv); end
    total++; if (dv !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", dv); end
  endtask

  task automatic test_edges;
    logic [3:0] xs [4] = '{4'd15, 4'd2, 4'd15, 4'd0};
    logic [3:0] ys [4] = '{4'd1,  4'd5, 4'd15, 4'd9};
    logic [3:0] qs [4] = '{4'd15, 4'd0, 4'd1,  4'd0};
    logic [3:0] rs [4] = '{4'd0,  4'd2, 4'd0,  4'd0};
    logic [3:0] qv, rv; logic dv; int lat;
    for (int i = 0; i < 4; i++) begin
      run4(xs[i], ys[i], qv, rv, dv, lat);
      total++; if (qv !== qs[i] || rv !== rs[i] || dv !== 1'b0 || lat !== 4) begin
        bad++; $display("FAIL edge_%0d_%0d got q=%0d r=%0d dbz=%b lat=%0d exp q=%0d r=%0d dbz=0 lat=4",
                        xs[i], ys[i], qv, rv, dv, lat, qs[i], rs[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    @(negedge clk); x4 = 4'd9; y4 = 4'd2; start4 = 1'b1;
    @(posedge clk); #1;
    // Keep requesting a different division throughout CALC and DONE.
    x4 = 4'd1; y4 = 4'd1;
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++; if (lat !== 4 || q4 !== 4'd4 || r4 !== 4'd1 || dbz4 !== 1'b0) begin
      bad++; $display("FAIL ignore_result got q=%0d r=%0d dbz=%b lat=%0d exp q=4 r=1 dbz=0 lat=4", q4, r4, dbz4, lat);
    end
    @(posedge clk); #1;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++; $display("FAIL ignore_start_on_done got busy=%b done=%b exp=0/0", busy4, done4);
    end
    start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (q4 !== 4'd4 || r4 !== 4'd1 || busy4 !== 1'b0) begin
      bad++; $display("FAIL ignore_hold got q=%0d r=%0d busy=%b exp q=4 r=1 busy=0", q4, r4, busy4);
    end
    @(negedge clk); x4 = 4'd15; y4 = 4'd15; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    total++; if (q4 !== 4'd4 || r4 !== 4'd1 || busy4 !== 1'b1) begin
      bad++; $display("FAIL hold_during_calc got q=%0d r=%0d busy=%b exp q=4 r=1 busy=1", q4, r4, busy4);
    end
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++; if (q4 !== 4'd1 || r4 !== 4'd0) begin
      bad++; $display("FAIL next_result got q=%0d r=%0d exp q=1 r=0", q4, r4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    logic [3:0] qv, rv; logic dv; int lat;
    run4(4'd13, 4'd3, qv, rv, dv, lat);
    @(negedge clk); x4 = 4'd7; y4 = 4'd2; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL midop_busy got=%b exp=1", busy4); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0 || q4 !== 4'd0 || r4 !== 4'd0 || dbz4 !== 1'b0) begin
      bad++; $display("FAIL midop_reset got busy=%b done=%b q=%0d r=%0d dbz=%b exp=all 0", busy4, done4, q4, r4, dbz4);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run4(4'd6, 4'd4, qv, rv, dv, lat);
    total++; if (qv !== 4'd1 || rv !== 4'd2 || dv !== 1'b0 || lat !== 4) begin
      bad++; $display("FAIL after_reset got q=%0d r=%0d dbz=%b lat=%0d exp q=1 r=2 dbz=0 lat=4", qv, rv, dv, lat);
    end
  endtask

  task automatic test_back_to_back_w2;
    logic [1:0] qv, rv; logic dv; int lat;
    logic [3:0] recon;
    for (int xi = 0; xi < 4; xi++) begin
      for (int yi = 0; yi < 4; yi++) begin
        run2(2'(xi), 2'(yi), qv, rv, dv, lat);
        if (yi == 0) begin
          total++; if (qv !== 2'd3 || rv !== 2'(xi) || dv !== 1'b1 || lat !== 0) begin
            bad++; $display("FAIL w2_dbz_%0d got q=%0d r=%0d dbz=%b lat=%0d exp q=3 r=%0d dbz=1 lat=0",
                            xi, qv, rv, dv, lat, xi);
          end
        end else begin
          recon = 4'(qv) * 4'(yi) + 4'(rv);
          total++; if (recon !== 4'(xi)) begin
            bad++; $display("FAIL w2_recon_%0d_%0d got q*y+r=%0d exp=%0d", xi, yi, recon, xi);
          end
          total++; if (!(rv < 2'(yi)) || dv !== 1'b0 || lat !== 2) begin
            bad++; $display("FAIL w2_rem_%0d_%0d got r=%0d dbz=%b lat=%0d exp r<%0d dbz=0 lat=2",
                            xi, yi, rv, dv, lat, yi);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_by_zero;
    test_edges;
    test_start_ignored;
    test_reset_midop;
    test_back_to_back_w2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
